fetch_unit: RTL and testbench
=============================

# fetch_unit

- Instruction fetch stage of the multicycle core.
- Holds the architectural program counter and issues one instruction-memory read per instruction over a request/ready/rvalid handshake.
- Presents the fetched word to decode.
- Loads the next PC from the branch unit's `new_pc` result when the core retires the current instruction; it is the consumer end of the branch unit's PC-redirect interface.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset; the block has one clock, reset is asynchronous and active-low
- `new_pc`  in  32  next PC from branch unit (already `pc+4` or target)
- `pc_update`  in  1  one-cycle pulse: current instruction retired, load `new_pc`
- `pc`  out  32  PC of the instruction currently held or being fetched
- `instr`  out  32  fetched instruction word
- `instr_valid`  out  1  `instr` is valid for `pc`
- `imem_req`  out  1  read request to instruction memory
- `imem_addr`  out  32  read address, equals `pc`
- `imem_ready`  in  1  memory accepts request this cycle
- `imem_rdata`  in  32  read data
- `imem_rvalid`  in  1  `imem_rdata` valid this cycle
- `misalign_fault`  out  1  sticky: a misaligned `new_pc` was loaded
- `instret`  out  32  retired-instruction counter

## Operation
- FSM states are IDLE, REQ, WAIT, HOLD and FAULT. State encodings are in `parameters.vh` (`FS_*`).
- **IDLE** (reset state): all outputs low, `pc`=`RESET_PC`. Goes unconditionally to REQ next cycle.
- **REQ**:
  - `imem_req`=1, `imem_addr`=`pc`.
  - Goes to WAIT on the cycle `imem_ready`=1.
  - `req` and `addr` are held stable until accepted.
  - `imem_rvalid` is ignored in REQ.
- **WAIT**:
  - `imem_req`=0.
  - On `imem_rvalid`=1: `instr`<=`imem_rdata`, `instr_valid`<=1, go to HOLD.
- **HOLD**:
  - `instr_valid`=1 and `instr` stable.
  - On `pc_update`=1 with `new_pc[1:0]`==0: `pc`<=`new_pc`, `instr_valid`<=0, `instret`<=`instret`+1, go to REQ.
  - On `pc_update`=1 with `new_pc[1:0]`!=0: `pc`<=`new_pc`, `instr_valid`<=0, `misalign_fault`<=1, go to FAULT. `instret` still increments.
- **FAULT**: terminal until reset. No requests, `instr_valid`=0, `misalign_fault`=1.
- `pc_update` outside HOLD is ignored: no PC change, no count.
- `instret` is 32-bit and wraps from 0xFFFF_FFFF to 0 without flagging.
- Reset while WAIT or REQ is outstanding:
  - All state returns to IDLE immediately.
  - A late `imem_rvalid` after reset is ignored, because it is only sampled in WAIT.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `instr`=0.
  - `instr_valid`=0, `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `misalign_fault`=0, `instret`=0.
- First request is asserted in the 1st cycle after `rst_n` deassertion edge plus one clock (the IDLE cycle).
- Minimum fetch latency, with `imem_ready` and `imem_rvalid` both in their earliest cycles:
  - REQ in cycle N, WAIT in N+1.
  - `instr_valid` high from N+2.
- `pc_update` in cycle M puts the new `pc` on `imem_addr`, with `imem_req`=1, in cycle M+1.
- Memory must not assert `imem_rvalid` in the same cycle as `imem_ready` for the same request. The rvalid is sampled no earlier than the next cycle.
- All outputs are registered, or decoded from the registered state only. There is no combinational path from any input to any output.

## Structure
- `parameters.vh` holds:
  - `FS_IDLE`/`FS_REQ`/`FS_WAIT`/`FS_HOLD`/`FS_FAULT` encodings (3 bits)
  - `RESET_PC` default
  - `INSTR_NOP` (32'h0000_0013) for reference in benches
- One natural sub-module: `instret_counter`, a 32-bit enable-controlled wrapping counter with async active-low reset.

## Test plan
- **Reset and first fetch.** Release reset, memory returns `imem_ready`=1 at once and rvalid one cycle later with 32'h0000_0013. Required response:
  - `imem_addr`=0 with `imem_req`=1 in the cycle after IDLE.
  - `instr_valid`=1 with `instr`=32'h0000_0013 two cycles later.
- **Backpressure.** Hold `imem_ready`=0 for 3 cycles. `imem_req` and `imem_addr`=0 must stay stable. Enter WAIT only on the ready cycle.
- **Branch redirect.** In HOLD, pulse `pc_update` with `new_pc`=32'h0000_0040. The next cycle must show `imem_addr`=0x40, `instr_valid`=0, `instret`=1.
- **Ignored update.** Pulse `pc_update` during WAIT. `pc` and `instret` must be unchanged.
- **Misaligned target.** In HOLD, `pc_update` with `new_pc`=32'h0000_0042. Required response:
  - `misalign_fault`=1 and state FAULT.
  - No further `imem_req` until reset.
- **Reset mid-fetch and counter wrap.**
  - Assert `rst_n`=0 in WAIT, then give rvalid after release. It must be ignored and fetch must restart at `RESET_PC`.
  - Force `instret`=0xFFFF_FFFF, then one update. `instret` must read 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared encodings and constants for the instruction fetch stage.
// Latency: none (definitions only).
// Backpressure: not applicable.
package fetch_unit_pkg;

  // FSM state encodings (3 bits)
  localparam logic [2:0] FS_IDLE  = 3'd0;
  localparam logic [2:0] FS_REQ   = 3'd1;
  localparam logic [2:0] FS_WAIT  = 3'd2;
  localparam logic [2:0] FS_HOLD  = 3'd3;
  localparam logic [2:0] FS_FAULT = 3'd4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE  = FS_IDLE,
    ST_REQ   = FS_REQ,
    ST_WAIT  = FS_WAIT,
    ST_HOLD  = FS_HOLD,
    ST_FAULT = FS_FAULT
  } fetch_state_t;

  // Instructions are word aligned; any low address bit set is a fault.
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_instret.sv
// Retired-instruction counter: wrapping up-counter with enable.
// Latency: count reflects an enable one cycle later.
// Backpressure: none; counts every enabled cycle, wraps silently.
module instret_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Increment on enable; natural overflow gives the wrap to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: holds PC, issues one imem read per instruction, presents word to decode.
// Latency: req in cycle N, accepted -> WAIT N+1, instr_valid from the cycle after rvalid.
// Backpressure: imem_req/imem_addr held until imem_ready; HOLD waits for pc_update.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] new_pc,
  input  logic        pc_update,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic        misalign_fault,
  output logic [31:0] instret
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         retire;

  // State register; reset drops any outstanding request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and retire strobe; pc_update only counts while holding an instruction.
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      ST_IDLE:  state_nxt = ST_REQ;
      ST_REQ:   if (imem_ready)  state_nxt = ST_WAIT;
      ST_WAIT:  if (imem_rvalid) state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (pc_update) begin
          retire    = 1'b1;
          state_nxt = is_aligned(new_pc) ? ST_REQ : ST_FAULT;
        end
      end
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture the returned word in WAIT, load the redirect PC on retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      if (state == ST_WAIT && imem_rvalid) begin
        instr_q <= imem_rdata;
      end
      if (retire) begin
        pc_q <= new_pc;
      end
    end
  end

  instret_counter #(
    .WIDTH (32)
  ) u_instret (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (retire),
    .count (instret)
  );

  // Outputs come from registers or the registered state only.
  assign pc             = pc_q;
  assign imem_addr      = pc_q;
  assign instr          = instr_q;
  assign imem_req       = (state == ST_REQ);
  assign instr_valid    = (state == ST_HOLD);
  assign misalign_fault = (state == ST_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed test-plan sequence, then randomized traffic.
// Latency: checks each cycle on the falling edge against a transaction-level model.
// Backpressure: imem_ready/imem_rvalid randomized.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] new_pc = '0;
  logic        pc_update = 1'b0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_rvalid = 1'b0;
  logic        misalign_fault;
  logic [31:0] instret;

  logic        wrap_en = 1'b0;
  logic [3:0]  wrap_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .new_pc         (new_pc),
    .pc_update      (pc_update),
    .pc             (pc),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .imem_rvalid    (imem_rvalid),
    .misalign_fault (misalign_fault),
    .instret        (instret)
  );

  // Narrow instance of the counter so the wrap can be reached in a few cycles.
  instret_counter #(.WIDTH(4)) u_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wrap_en),
    .count (wrap_cnt)
  );

  // Transaction-level model: what the fetch stage owes the outside world.
  bit          m_started;     // IDLE cycle after reset has elapsed
  bit          m_req_open;    // a read request is being offered
  bit          m_data_owed;   // request accepted, data not yet returned
  bit          m_have_instr;  // instruction presented to decode
  bit          m_faulted;
  logic [31:0] m_pc, m_instr, m_instret;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_req_open = 0; m_data_owed = 0;
    m_have_instr = 0; m_faulted = 0;
    m_pc = DEFAULT_RESET_PC; m_instr = '0; m_instret = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},          pc,                     m_pc);
    chk({tag, ".addr"},        imem_addr,              m_pc);
    chk({tag, ".instr"},       instr,                  m_instr);
    chk({tag, ".instr_valid"}, {31'd0, instr_valid},   {31'd0, m_have_instr});
    chk({tag, ".req"},         {31'd0, imem_req},      {31'd0, m_req_open});
    chk({tag, ".fault"},       {31'd0, misalign_fault},{31'd0, m_faulted});
    chk({tag, ".instret"},     instret,                m_instret);
  endtask

  // Apply inputs for one cycle, advance the model at the edge, check on the falling edge.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rd,
                      input logic up, input logic [31:0] np);
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
    pc_update = up; new_pc = np;
    @(posedge clk);
    if (!m_started) begin
      m_started = 1; m_req_open = 1;
    end else if (m_faulted) begin
      // terminal until reset
    end else if (m_req_open) begin
      if (rdy) begin m_req_open = 0; m_data_owed = 1; end
    end else if (m_data_owed) begin
      if (rv) begin m_instr = rd; m_data_owed = 0; m_have_instr = 1; end
    end else if (m_have_instr && up) begin
      m_pc = np;
      m_instret = m_instret + 32'd1;
      m_have_instr = 0;
      if (np % 4 != 0) m_faulted = 1;
      else             m_req_open = 1;
    end
    @(negedge clk);
    check_all("cyc");
  endtask

  // Asynchronous reset asserted mid-cycle, released on a falling edge.
  task automatic do_reset();
    imem_ready = 0; imem_rvalid = 0; pc_update = 0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] np;
    int fault_cycles;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset and first fetch
    step(1, 0, 0, 0, 0);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    step(1, 0, 0, 0, 0);
    step(0, 1, INSTR_NOP, 0, 0);
    chk("first_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_instr", instr, INSTR_NOP);

    // Branch redirect
    step(0, 0, 0, 1, 32'h40);
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_instret", instret, 32'd1);

    // Backpressure on the redirected fetch
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'hBAD0_0000, 0, 0);
      chk("bp_req", {31'd0, imem_req}, 32'd1);
      chk("bp_addr", imem_addr, 32'h40);
    end
    step(1, 0, 0, 0, 0);
    chk("bp_accept", {31'd0, imem_req}, 32'd0);

    // Ignored update during WAIT
    step(0, 0, 0, 1, 32'h80);
    chk("ign_pc", pc, 32'h40);
    chk("ign_instret", instret, 32'd1);
    step(0, 1, 32'hDEAD_BEEF, 0, 0);

    // Misaligned target
    step(0, 0, 0, 1, 32'h42);
    chk("mis_fault", {31'd0, misalign_fault}, 32'd1);
    chk("mis_instret", instret, 32'd2);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 32'h1111_1111, 1, 32'h100);
      chk("mis_noreq", {31'd0, imem_req}, 32'd0);
    end

    // Reset mid-fetch with a late rvalid
    do_reset();
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("bp0_addr", imem_addr, DEFAULT_RESET_PC);
    end
    step(1, 0, 0, 0, 0);
    do_reset();
    step(0, 1, 32'h1234_5678, 0, 0);
    step(0, 1, 32'h1234_5678, 0, 0);
    chk("late_rvalid_valid", {31'd0, instr_valid}, 32'd0);
    chk("late_rvalid_addr", imem_addr, DEFAULT_RESET_PC);

    // Counter wrap
    wrap_en = 1'b1;
    repeat (15) @(negedge clk);
    chk("wrap_max", {28'd0, wrap_cnt}, 32'd15);
    @(negedge clk);
    chk("wrap_zero", {28'd0, wrap_cnt}, 32'd0);
    wrap_en = 1'b0;

    // Randomized traffic
    do_reset();
    fault_cycles = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0 || fault_cycles > 6) begin
        do_reset();
        fault_cycles = 0;
      end
      np = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) np = np | 32'($urandom_range(1, 3));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 2) == 0), np);
      if (m_faulted) fault_cycles++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
